// File: rtl/game_pkg.sv
// Shared definitions for the 2048 game blocks: board geometry, tile exponents,
// spawner FSM states and by-index cell access helpers.
package game_pkg;

  localparam int N_CELLS = 16;
  localparam int CELL_W  = 4;
  localparam int IDX_W   = 4;
  localparam int BOARD_W = N_CELLS * CELL_W;

  localparam logic [CELL_W-1:0] EXP_EMPTY = 4'd0;
  localparam logic [CELL_W-1:0] EXP_TWO   = 4'd1;
  localparam logic [CELL_W-1:0] EXP_FOUR  = 4'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } spawn_state_e;

  function automatic logic [CELL_W-1:0] cell_get(input logic [BOARD_W-1:0] b,
                                                 input logic [IDX_W-1:0]   i);
    return b[i*CELL_W +: CELL_W];
  endfunction

  function automatic logic [BOARD_W-1:0] cell_set(input logic [BOARD_W-1:0] b,
                                                  input logic [IDX_W-1:0]   i,
                                                  input logic [CELL_W-1:0]  v);
    logic [BOARD_W-1:0] r;
    r = b;
    r[i*CELL_W +: CELL_W] = v;
    return r;
  endfunction

endpackage

// File: rtl/tile_spawner.sv
// Places one new tile on the board after a move: wrap-around scan for an empty
// cell starting at a random index, then a one-cycle spawn_done with the result.
module tile_spawner
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               spawn_req,
  input  logic [BOARD_W-1:0] board_in,
  input  logic [CELL_W-1:0]  rnd,
  output logic [BOARD_W-1:0] board_out,
  output logic               spawn_done,
  output logic               no_space,
  output logic               busy,
  output spawn_state_e       state
);

  // Handshake: spawn_req is a one-cycle request taken only in IDLE (otherwise
  // dropped); busy covers SCAN and DONE; spawn_done pulses once with board_out
  // and no_space valid, and those two hold until the next DONE.

  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(N_CELLS - 1);

  logic [BOARD_W-1:0] board_q;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   cnt;
  logic [CELL_W-1:0]  probe;
  logic [CELL_W-1:0]  new_exp;

  assign probe   = cell_get(board_q, idx);
  assign new_exp = (rnd == 4'h0) ? EXP_FOUR : EXP_TWO;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      board_q    <= '0;
      board_out  <= '0;
      idx        <= '0;
      cnt        <= '0;
      spawn_done <= 1'b0;
      no_space   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      spawn_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (spawn_req) begin
            board_q <= board_in;
            idx     <= rnd;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (probe == EXP_EMPTY) begin
            // rnd is re-sampled here so tile size is independent of the start cell
            board_q    <= cell_set(board_q, idx, new_exp);
            board_out  <= cell_set(board_q, idx, new_exp);
            no_space   <= 1'b0;
            spawn_done <= 1'b1;
            state      <= ST_DONE;
          end else if (cnt == LAST_CNT) begin
            board_out  <= board_q;
            no_space   <= 1'b1;
            spawn_done <= 1'b1;
            state      <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
